// File: rtl/rv_alu_seq.sv
// rv_alu_seq: handshaked RV32I register-register ALU, WIDTH-generic.
// Shifts run serially, one bit position per clock; all other ops finish in
// one cycle.
//
// Ports
//   clk        clock, rising-edge
//   rst        synchronous active-high reset
//   in_valid   operand/op presented by source
//   in_ready   block can accept (IDLE only)
//   op         {funct7[5], funct3}
//   a, b       operands
//   out_valid  result/flags valid (DONE)
//   out_ready  sink accepts result
//   result     registered result
//   zero       result == 0
//   carry      ADD carry-out / SUB not-borrow, else 0
//   err        op code was illegal
//   busy       state != IDLE
module rv_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             err,
  output logic             busy
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_err;

  logic             w_accept;
  logic             w_legal;
  logic             w_is_shift;
  logic             w_shamt_zero;
  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_carry;
  logic [WIDTH-1:0] w_sh_next;

  assign w_accept     = in_valid && (r_state == S_IDLE);
  assign w_shamt_zero = (b[SHW-1:0] == '0);
  assign w_last       = (r_cnt == SHW'(1));

  // Op decode
  always_comb begin
    w_legal    = 1'b1;
    w_is_shift = 1'b0;
    case (op)
      4'b0001, 4'b0101, 4'b1101:                   w_is_shift = 1'b1;
      4'b0000, 4'b1000, 4'b0010, 4'b0011,
      4'b0100, 4'b0110, 4'b0111:                   w_is_shift = 1'b0;
      default:                                     w_legal    = 1'b0;
    endcase
  end

  // Single-cycle ops; SUB is a + ~b + 1 so carry is NOT borrow
  always_comb begin
    w_sum       = '0;
    w_alu       = '0;
    w_alu_carry = 1'b0;
    case (op)
      4'b0000: begin
        w_sum       = {1'b0, a} + {1'b0, b};
        w_alu       = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      4'b1000: begin
        w_sum       = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        w_alu       = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      4'b0010: w_alu[0] = ($signed(a) < $signed(b));
      4'b0011: w_alu[0] = (a < b);
      4'b0100: w_alu    = a ^ b;
      4'b0110: w_alu    = a | b;
      4'b0111: w_alu    = a & b;
      default: w_alu    = '0;
    endcase
  end

  // One-position serial shift step
  always_comb begin
    case (r_op)
      4'b0001: w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
      4'b0101: w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
      default: w_sh_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) begin
                 if (w_legal && w_is_shift && !w_shamt_zero) w_next = S_SHIFT;
                 else                                        w_next = S_DONE;
               end
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_DONE);
    result    = r_result;
    zero      = r_zero;
    carry     = r_carry;
    err       = r_err;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= op;
          r_sh  <= a;
          r_cnt <= b[SHW-1:0];
          if (!w_legal) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_carry  <= 1'b0;
            r_err    <= 1'b1;
          end else if (w_is_shift) begin
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            if (w_shamt_zero) begin
              r_result <= a;
              r_zero   <= (a == '0);
            end
          end else begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
            r_carry  <= w_alu_carry;
            r_err    <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt - SHW'(1);
          if (w_last) begin
            r_result <= w_sh_next;
            r_zero   <= (w_sh_next == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_alu_seq.sv
// Testbench for rv_alu_seq: WIDTH=8 and WIDTH=32 instances driven from one
// shared stimulus bus; sel chooses which instance sees in_valid.
module tb_rv_alu_seq;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, sel;
  logic [3:0]  op;
  logic [31:0] a, b;

  logic        rdy8, ov8, z8, c8, e8, bz8;
  logic [7:0]  res8;
  logic        rdy32, ov32, z32, c32, e32, bz32;
  logic [31:0] res32;

  rv_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(rdy8),
    .op(op), .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .zero(z8), .carry(c8), .err(e8), .busy(bz8)
  );

  rv_alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(rdy32),
    .op(op), .a(a), .b(b), .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .zero(z32), .carry(c32), .err(e32), .busy(bz32)
  );

  logic        obs_ready, obs_valid, obs_zero, obs_carry, obs_err, obs_busy;
  logic [31:0] obs_res;
  assign obs_ready = sel ? rdy32 : rdy8;
  assign obs_valid = sel ? ov32  : ov8;
  assign obs_zero  = sel ? z32   : z8;
  assign obs_carry = sel ? c32   : c8;
  assign obs_err   = sel ? e32   : e8;
  assign obs_busy  = sel ? bz32  : bz8;
  assign obs_res   = sel ? res32 : {24'd0, res8};

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_res;
  logic        cap_z, cap_c, cap_e;
  int          cap_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RV32I semantics via plain wide arithmetic on a w-bit value
  function automatic void model(input int w, input logic [3:0] o,
                                input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic c,
                                output logic z, output logic e, output int lat);
    logic [63:0] mask;
    logic [64:0] s;
    longint      sx, sy;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    sx   = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy   = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    sh   = int'(y % 64'(w));
    r = '0; c = 1'b0; e = 1'b0; lat = 1; s = '0;
    case (o)
      4'h0: begin s = 65'(x) + 65'(y); r = s[63:0] & mask; c = s[w]; end
      4'h8: begin s = 65'(x) + 65'((~y) & mask) + 65'd1; r = s[63:0] & mask; c = s[w]; end
      4'h2: r = (sx < sy) ? 64'd1 : 64'd0;
      4'h3: r = (x < y) ? 64'd1 : 64'd0;
      4'h4: r = x ^ y;
      4'h6: r = x | y;
      4'h7: r = x & y;
      4'h1: begin r = (x << sh) & mask;        lat = 1 + sh; end
      4'h5: begin r = x >> sh;                 lat = 1 + sh; end
      4'hD: begin r = 64'(sx >>> sh) & mask;   lat = 1 + sh; end
      default: e = 1'b1;
    endcase
    z = (r == 64'd0);
  endfunction

  // Issue one op, check latency/flags, optionally backpressure for hold cycles
  task automatic run_op(input int w, input logic [3:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input int hold);
    logic [63:0] mask, er;
    logic        ec, ez, ee;
    int          elat, lat, t;
    mask = (64'd1 << w) - 64'd1;
    model(w, o, 64'(aa) & mask, 64'(bb) & mask, er, ec, ez, ee, elat);
    t = 0;
    while (!obs_ready && t < 50) begin @(negedge clk); t++; end
    chk("in_ready_before_issue", 64'(obs_ready), 64'd1);
    op = o; a = aa; b = bb; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    #1;
    if (hold == 0) in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!obs_valid && lat < 100) begin
      chk("busy_while_shift", 64'(obs_busy), 64'd1);
      chk("in_ready_while_shift", 64'(obs_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    cap_lat = lat; cap_res = 64'(obs_res); cap_z = obs_zero; cap_c = obs_carry; cap_e = obs_err;
    chk("latency", 64'(lat), 64'(elat));
    chk("result", 64'(obs_res), er);
    chk("zero", 64'(obs_zero), 64'(ez));
    chk("carry", 64'(obs_carry), 64'(ec));
    chk("err", 64'(obs_err), 64'(ee));
    chk("in_ready_done", 64'(obs_ready), 64'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("bp_out_valid", 64'(obs_valid), 64'd1);
        chk("bp_in_ready", 64'(obs_ready), 64'd0);
        chk("bp_result", 64'(obs_res), er);
        chk("bp_flags", {61'd0, obs_zero, obs_carry, obs_err}, {61'd0, ez, ec, ee});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_after_hs", 64'(obs_valid), 64'd0);
    chk("in_ready_after_hs", 64'(obs_ready), 64'd1);
    chk("busy_after_hs", 64'(obs_busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(rdy8), 64'd1);
    chk("rst_out_valid", 64'(ov8), 64'd0);
    chk("rst_result", 64'(res8), 64'd0);
    chk("rst_flags", {60'd0, z8, c8, e8, bz8}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed, WIDTH=8
    run_op(8, 4'h0, 32'hF0, 32'h20, 0);
    chk("add_lit", {cap_res[7:0], 3'd0, cap_c, cap_z}, {8'h10, 3'd0, 1'b1, 1'b0});
    run_op(8, 4'h8, 32'h05, 32'h05, 0);
    chk("sub_eq_lit", {cap_res[7:0], cap_c, cap_z}, {8'h00, 1'b1, 1'b1});
    run_op(8, 4'h8, 32'h03, 32'h05, 0);
    chk("sub_lt_lit", {cap_res[7:0], cap_c}, {8'hFE, 1'b0});
    run_op(8, 4'h2, 32'h80, 32'h01, 0);
    chk("slt_lit", cap_res, 64'd1);
    run_op(8, 4'h3, 32'h80, 32'h01, 0);
    chk("sltu_lit", cap_res, 64'd0);
    run_op(8, 4'hD, 32'h80, 32'h03, 0);
    chk("sra_lit", {cap_res[7:0], 8'(cap_lat)}, {8'hF0, 8'd4});
    run_op(8, 4'h1, 32'h81, 32'h09, 0);
    chk("sll_lit", {cap_res[7:0], 8'(cap_lat)}, {8'h02, 8'd2});
    run_op(8, 4'h5, 32'h01, 32'h01, 0);
    chk("srl_lit", {cap_res[7:0], 7'd0, cap_z}, {8'h00, 7'd0, 1'b1});
    run_op(8, 4'h5, 32'hA5, 32'h08, 0);
    run_op(8, 4'h7, 32'h3C, 32'h0F, 5);
    run_op(8, 4'hF, 32'h12, 32'h34, 0);
    chk("illegal_lit", {cap_res[7:0], 6'd0, cap_e, cap_z}, {8'h00, 6'd0, 1'b1, 1'b1});
    run_op(8, 4'h4, 32'h12, 32'h34, 0);
    chk("err_cleared", 64'(cap_e), 64'd0);

    // Reset during SHIFT
    run_op(8, 4'h0, 32'hF0, 32'h20, 0);
    op = 4'h1; a = 32'h5A; b = 32'h07; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(ov8), 64'd0);
    chk("midrst_result", 64'(res8), 64'd0);
    chk("midrst_in_ready", 64'(rdy8), 64'd1);
    chk("midrst_flags", {60'd0, z8, c8, e8, bz8}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(8, 4'h0, 32'h01, 32'h01, 0);
    chk("post_rst_add", {cap_res[7:0], 8'(cap_lat)}, {8'h02, 8'd1});

    // Random, WIDTH=8
    for (int i = 0; i < 150; i++) begin
      int hold;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_op(8, 4'($urandom_range(0, 15)), $urandom, $urandom, hold);
    end

    // WIDTH=32
    sel = 1'b1;
    @(negedge clk);
    run_op(32, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    chk("add32_lit", {cap_res[31:0], 31'd0, cap_c}, {32'h0, 31'd0, 1'b1});
    run_op(32, 4'hD, 32'h8000_0000, 32'd31, 0);
    chk("sra32_lit", {cap_res[31:0], 32'(cap_lat)}, {32'hFFFF_FFFF, 32'd32});
    run_op(32, 4'h2, 32'h8000_0000, 32'h0000_0001, 0);
    chk("slt32_lit", cap_res, 64'd1);
    for (int i = 0; i < 40; i++) begin
      run_op(32, 4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_alu_seq.md
# rv_alu_seq

Parametrised, handshaked ALU covering the RV32I integer register-register operation set. Shifts are computed serially, one bit position per cycle. It is the next generation of the hands-on datapath: the 8-bit combinational adder becomes a WIDTH-generic execution unit with valid/ready flow control. It sits between the operand source (pin decode or a future register file) and the result sink, inside the Tiny Tapeout top.

## Interface
- WIDTH, 8, operand/result width; must be a power of two, 4..64.
- SHW (localparam), $clog2(WIDTH), shift-amount width.
- clk  in  1  single clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  4  {funct7[5], funct3}:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU
  - 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND
  - any other code is illegal.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  sink accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- carry  out  1  ADD: carry-out; SUB: NOT borrow, i.e. carry of a + ~b + 1; all other ops: 0.
- err  out  1  op was illegal.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid && in_ready, latch op, a, b.
  - Non-shift op: compute result and flags into output registers, go to DONE.
  - Shift op (SLL/SRL/SRA): load shift register with a and counter with b[SHW-1:0]; upper bits of b are ignored.
    - Counter 0: result = a, go to DONE.
    - Otherwise go to SHIFT.
  - Illegal op: result = 0, zero = 1, carry = 0, err = 1, go to DONE.
- SHIFT
  - Each cycle, shift the register by one: SLL shifts in 0 at the LSB; SRL shifts in 0 at the MSB; SRA replicates the MSB.
  - Decrement the counter.
  - When the counter reaches 1 → 0, write the final value to result, set zero, and go to DONE.
- DONE
  - out_valid = 1; result, zero, carry and err held stable.
  - On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
  - in_ready stays 0 in DONE; no accept occurs in the same cycle as the output handshake.
- Arithmetic rules:
  - ADD/SUB are modulo 2^WIDTH.
  - SLT is a signed two's-complement compare; SLTU is unsigned. Both return 0 or 1, zero-extended.
  - Logical ops are bitwise.
- in_valid while in_ready = 0 is ignored; the source must hold it.
- Reset, in any state including mid-SHIFT:
  - Next state is IDLE; any in-flight operation is discarded.
  - result = 0, zero = 0, carry = 0, err = 0, out_valid = 0, busy = 0, in_ready = 1 after the reset cycle.
- Reset takes priority over every handshake in the same cycle.

## Timing
- Acceptance edge = cycle 0.
- Non-shift, illegal, and shift-by-0 ops: out_valid high from cycle 1.
- Shift by n (1..WIDTH-1): out_valid high from cycle 1+n; busy high cycles 1..1+n until the output handshake.
- Minimum issue interval, no backpressure:
  - 2 cycles for single-cycle ops (accept, DONE/handshake, back to IDLE).
  - 2+n cycles for shifts.
- Outputs are registered; no combinational path from in_* to out_*.
- in_ready is a function of state only; it is not a function of out_ready.

## Test plan
- ADD (WIDTH=8): a=0xF0, b=0x20 → cycle 1: out_valid=1, result=0x10, carry=1, zero=0; out_ready=1 → IDLE at cycle 2, in_ready=1.
- SUB/compare:
  - SUB 0x05−0x05 → result 0x00, zero=1, carry=1.
  - SUB 0x03−0x05 → 0xFE, carry=0.
  - SLT 0x80,0x01 → 1.
  - SLTU 0x80,0x01 → 0.
- Serial shifts:
  - SRA a=0x80, b=0x03 → in_ready low, out_valid at cycle 4, result=0xF0.
  - SLL a=0x81, b=0x09 (shamt 1) → 0x02 at cycle 2.
  - SRL a=0x01, b=0x01 → 0x00, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after any result → result and flags stable; in_valid held high is not accepted; release → next op accepted the cycle after the handshake.
- Illegal op 1111 → cycle 1: err=1, result=0x00, zero=1; the next legal op clears err.
- Reset mid-SHIFT: SLL by 7, assert rst at cycle 3 → next cycle out_valid=0, result=0, in_ready=1; then ADD 1+1 → 0x02 at cycle 1.
- Rerun ADD, SRA and SLT with WIDTH=32: SRA 0x80000000 by 31 → 0xFFFFFFFF at cycle 32.
